// File: rtl/mips_pkg.sv
// Shared definitions for the SingleCycleMIPS program loader: FSM states and framing constants.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_BYTES,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Words arrive least-significant byte first; byte index 3 completes a word.
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

    function automatic logic is_timed(input ld_state_t s);
        return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_BYTES);
    endfunction

endpackage

// File: rtl/ld_timer.sv
// Saturating idle-cycle counter; hit flags the cycle that would complete TIMEOUT idle cycles.
module ld_timer #(
    parameter int TIMEOUT = 1000,
    localparam int W = $clog2(TIMEOUT + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam logic [W-1:0] LIMIT  = W'(TIMEOUT);
    localparam logic [W-1:0] HIT_AT = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // A byte accepted in the same cycle clears the timer and takes priority in the FSM.
    assign hit = enable && (count >= HIT_AT);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses A5 / count / LSB-first words and writes them into
// instruction memory, holding the core in reset until the whole image is in place.
module prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              WE,
    output logic [31:0]       W_Ins,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    ld_state_t     state;
    logic [7:0]    count_lo;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [ADDR_W:0] remaining;
    logic          accept;
    logic          timed;
    logic          timeout_hit;
    logic [15:0]   n_word;

    assign accept = rx_valid && rx_ready;
    assign timed  = is_timed(state);
    assign n_word = {rx_data, count_lo};

    ld_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (accept || !timed),
        .enable (timed),
        .hit    (timeout_hit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            rx_ready  <= 1'b1;
            WE        <= 1'b0;
            W_Ins     <= '0;
            W_Addr    <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            count_lo  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (rx_data == SYNC_BYTE)) begin
                        state <= ST_CNT_LO;
                    end
                end

                ST_CNT_LO: begin
                    if (accept) begin
                        count_lo <= rx_data;
                        state    <= ST_CNT_HI;
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end
                end

                ST_CNT_HI: begin
                    if (accept) begin
                        if (n_word == 16'd0) begin
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                            state     <= ST_DONE;
                        end else if ({1'b0, n_word} > CAPACITY) begin
                            err   <= 1'b1;
                            state <= ST_ERR;
                        end else begin
                            W_Addr    <= '0;
                            remaining <= n_word[ADDR_W:0];
                            byte_idx  <= '0;
                            state     <= ST_BYTES;
                        end
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end
                end

                // Bytes shift in from the top so after three of them word_buf holds {b2,b1,b0}.
                ST_BYTES: begin
                    if (accept) begin
                        if (byte_idx == LAST_BYTE_IDX) begin
                            W_Ins    <= {rx_data, word_buf};
                            WE       <= 1'b1;
                            rx_ready <= 1'b0;
                            byte_idx <= '0;
                            state    <= ST_WRITE;
                        end else begin
                            word_buf <= {rx_data, word_buf[23:8]};
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end
                end

                ST_WRITE: begin
                    WE        <= 1'b0;
                    rx_ready  <= 1'b1;
                    W_Addr    <= W_Addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == (ADDR_W + 1)'(1)) begin
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                        state     <= ST_DONE;
                    end else begin
                        state <= ST_BYTES;
                    end
                end

                ST_DONE, ST_ERR: begin
                    if (accept && (rx_data == SYNC_BYTE)) begin
                        done      <= 1'b0;
                        err       <= 1'b0;
                        core_hold <= 1'b1;
                        state     <= ST_CNT_LO;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: framing, writes, errors, timeout and reset.
module tb_prog_loader;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 1000;

    logic              CLK = 1'b0;
    logic              RST;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              WE;
    logic [31:0]       W_Ins;
    logic [ADDR_W-1:0] W_Addr;
    logic              core_hold;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W+31:0] wq[$];

    prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .WE        (WE),
        .W_Ins     (W_Ins),
        .W_Addr    (W_Addr),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // Every write strobe is logged with its address for later comparison.
    always @(negedge CLK) begin
        if (WE === 1'b1) wq.push_back({W_Addr, W_Ins});
    end

    task automatic send_byte(input logic [7:0] b);
        bit sent = 0;
        for (int i = 0; i < 20 && !sent; i++) begin
            @(negedge CLK);
            if (rx_ready === 1'b1) begin
                rx_data  = b;
                rx_valid = 1'b1;
                @(posedge CLK);
                #1;
                rx_valid = 1'b0;
                sent = 1;
            end
        end
        checks++;
        if (!sent) begin
            errors++;
            $display("[TB] FAIL send_byte_ready: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        RST      = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({rx_ready, WE, W_Ins, W_Addr, core_hold, done, err} !==
            {1'b1, 1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rdy=%b we=%b ins=%h addr=%0d hold=%b done=%b err=%b required 1 0 0 0 1 0 0",
                     rx_ready, WE, W_Ins, W_Addr, core_hold, done, err);
        end
    endtask

    task automatic test_two_words();
        logic [7:0] img [11] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wq.delete();
        for (int i = 0; i < 11; i++) begin
            send_byte(img[i]);
            if (i == 6 || i == 10) begin
                checks++;
                if ({WE, W_Addr, W_Ins} !== {1'b1, (i == 6) ? 6'd0 : 6'd1,
                                             (i == 6) ? 32'h12345678 : 32'hDEADBEEF}) begin
                    errors++;
                    $display("[TB] FAIL write_latency_%0d: we=%b addr=%0d ins=%h", i, WE, W_Addr, W_Ins);
                end
            end
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({done, core_hold, err} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL two_words_done: done=%b hold=%b err=%b required 1 0 0", done, core_hold, err);
        end
        checks++;
        if (wq.size() != 2 || wq[0] !== {6'd0, 32'h12345678} || wq[1] !== {6'd1, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL two_words_log: %0d writes logged, required 2 (0,12345678) (1,DEADBEEF)", wq.size());
        end
    endtask

    task automatic test_noise();
        logic [7:0] img [10] = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h00,
                                 8'h44, 8'h33, 8'h22, 8'h11};
        do_reset();
        wq.delete();
        for (int i = 0; i < 10; i++) send_byte(img[i]);
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (wq.size() != 1 || wq[0] !== {6'd0, 32'h11223344}) begin
            errors++;
            $display("[TB] FAIL noise_write: %0d writes logged, required 1 at (0,11223344)", wq.size());
        end
        checks++;
        if ({done, core_hold} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL noise_done: done=%b hold=%b required 1 0", done, core_hold);
        end
    endtask

    task automatic test_zero_count();
        wq.delete();
        send_byte(8'hA5);
        checks++;
        if ({done, core_hold} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL restart_clears_done: done=%b hold=%b required 0 1", done, core_hold);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if ({done, core_hold, err} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL zero_count_done: done=%b hold=%b err=%b required 1 0 0", done, core_hold, err);
        end
        repeat (2) @(posedge CLK);
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_count_no_we: %0d writes logged, required 0", wq.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] img [7] = '{8'hA5, 8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        wq.delete();
        send_byte(8'hA5);
        send_byte(8'h41);
        send_byte(8'h00);
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({err, core_hold, done} !== 3'b110 || wq.size() != 0) begin
            errors++;
            $display("[TB] FAIL overflow_err: err=%b hold=%b done=%b writes=%0d required 1 1 0 0",
                     err, core_hold, done, wq.size());
        end
        send_byte(img[0]);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_sync_clears: err=%b required 0", err);
        end
        for (int i = 1; i < 7; i++) send_byte(img[i]);
        @(posedge CLK);
        #1;
        checks++;
        if (wq.size() != 1 || wq[0] !== {6'd0, 32'hAABBCCDD} || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_recover: writes=%0d done=%b required 1 write (0,AABBCCDD) done 1",
                     wq.size(), done);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TIMEOUT - 1) @(posedge CLK);
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_early: err=%b required 0", err);
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({err, core_hold} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL timeout_err: err=%b hold=%b required 1 1", err, core_hold);
        end

        wq.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TIMEOUT - 1) @(posedge CLK);
        #1;
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_byte_wins: err=%b required 0", err);
        end
        send_byte(8'h44);
        checks++;
        if ({WE, W_Ins} !== {1'b1, 32'h44332211}) begin
            errors++;
            $display("[TB] FAIL timeout_variant_write: we=%b ins=%h required 1 44332211", WE, W_Ins);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] img [7] = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 7; i++) begin
            send_byte(img[i]);
            @(posedge CLK);
        end
        @(posedge CLK);
        send_byte(8'h05);
        @(posedge CLK);
        send_byte(8'h06);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({rx_ready, WE, W_Ins, W_Addr, core_hold, done, err} !==
            {1'b1, 1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset: rdy=%b we=%b ins=%h addr=%0d hold=%b done=%b err=%b required 1 0 0 0 1 0 0",
                     rx_ready, WE, W_Ins, W_Addr, core_hold, done, err);
        end
        @(negedge CLK);
        RST = 1'b1;
        wq.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h0D);
        send_byte(8'hF0);
        send_byte(8'hAD);
        send_byte(8'h8B);
        @(posedge CLK);
        #1;
        checks++;
        if (wq.size() != 1 || wq[0] !== {6'd0, 32'h8BADF00D} || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload_after_reset: writes=%0d done=%b required 1 write (0,8BADF00D) done 1",
                     wq.size(), done);
        end
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        RST      = 1'b0;
        test_reset();
        test_two_words();
        test_noise();
        test_zero_count();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
